blip_burst_gen: RTL and testbench

- Aggressor-side pulse source for the crosstalk event counter; the counter receives and counts these pulses on its blip clock input.
- Emits a programmed burst of N clean pulses with programmable high width and low gap on `blip_out`. The count read back from the counter can then be compared against a known stimulus.
- Sits in the same user-project wrapper as the counter. Output routes to the aggressor line or to the counter's event input.

---
 rtl/blip_burst_gen_if.sv | 27 ++
 rtl/blip_burst_gen.sv | 115 +++++++++++
 tb/tb_blip_burst_gen.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/blip_burst_gen_if.sv
// Control/status bundle for blip_burst_gen: burst request fields in, pulse train and status out.
interface blip_burst_gen_if #(
  parameter int CNT_W   = 8,
  parameter int WIDTH_W = 4,
  parameter int GAP_W   = 8
) ();
  logic               start;
  logic               abort;
  logic [CNT_W-1:0]   burst_len;
  logic [WIDTH_W-1:0] pulse_width;
  logic [GAP_W-1:0]   gap_len;
  logic               blip_out;
  logic               busy;
  logic               done;
  logic               aborted;
  logic [CNT_W-1:0]   sent_count;

  modport master (
    output start, abort, burst_len, pulse_width, gap_len,
    input  blip_out, busy, done, aborted, sent_count
  );

  modport slave (
    input  start, abort, burst_len, pulse_width, gap_len,
    output blip_out, busy, done, aborted, sent_count
  );
endinterface

// File: rtl/blip_burst_gen.sv
// Programmable burst pulse source (N pulses, W high / G low cycles) feeding the crosstalk counter.
// Optional macro BLIP_CONTINUOUS_EN: burst_len=0 free-runs until abort.
module blip_burst_gen #(
  parameter int CNT_W   = 8,
  parameter int WIDTH_W = 4,
  parameter int GAP_W   = 8
) (
  input logic              wb_clk_i,
  input logic              wb_rst_i,
  blip_burst_gen_if.slave  bus
);
  localparam int PH_W = (WIDTH_W > GAP_W) ? WIDTH_W : GAP_W;

  typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, GAP = 2'd2} state_t;

  state_t             state;
  logic [CNT_W-1:0]   n_lat;
  logic [CNT_W-1:0]   sent;
  logic [WIDTH_W-1:0] w_lat;
  logic [GAP_W-1:0]   g_lat;
  logic [PH_W-1:0]    ph;
  logic               free_run;
  logic               blip;
  logic               busy;
  logic               done;
  logic               aborted;

  logic [WIDTH_W-1:0] w_in;
  logic [GAP_W-1:0]   g_in;
  logic               free_req;

  // zero width/gap clamp to one cycle so the sink always sees separate edges
  assign w_in = (bus.pulse_width == '0) ? WIDTH_W'(1) : bus.pulse_width;
  assign g_in = (bus.gap_len == '0) ? GAP_W'(1) : bus.gap_len;

`ifdef BLIP_CONTINUOUS_EN
  assign free_req = (bus.burst_len == '0);
`else
  assign free_req = 1'b0;
`endif

  // ph counts remaining cycles of the current HIGH or GAP phase, minus one
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      n_lat    <= '0;
      w_lat    <= '0;
      g_lat    <= '0;
      ph       <= '0;
      free_run <= 1'b0;
      sent     <= '0;
      blip     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            n_lat    <= bus.burst_len;
            w_lat    <= w_in;
            g_lat    <= g_in;
            free_run <= free_req;
            sent     <= '0;
            if (bus.burst_len != '0 || free_req) begin
              state <= HIGH;
              blip  <= 1'b1;
              busy  <= 1'b1;
              sent  <= CNT_W'(1);
              ph    <= PH_W'(w_in - WIDTH_W'(1));
            end else begin
              done <= 1'b1;
            end
          end
        end
        HIGH, GAP: begin
          if (bus.abort) begin
            state   <= IDLE;
            blip    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else if (ph != '0) begin
            ph <= ph - PH_W'(1);
          end else if (state == HIGH) begin
            if (!free_run && sent == n_lat) begin
              state <= IDLE;
              blip  <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= GAP;
              blip  <= 1'b0;
              ph    <= PH_W'(g_lat - GAP_W'(1));
            end
          end else begin
            state <= HIGH;
            blip  <= 1'b1;
            sent  <= sent + CNT_W'(1);
            ph    <= PH_W'(w_lat - WIDTH_W'(1));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.blip_out   = blip;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.aborted    = aborted;
  assign bus.sent_count = sent;
endmodule

// File: tb/tb_blip_burst_gen.sv
// Bench for blip_burst_gen: formula-based burst model checked every cycle, plus directed literal cases.
module tb_blip_burst_gen;
  localparam int CNT_W   = 8;
  localparam int WIDTH_W = 4;
  localparam int GAP_W   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  blip_burst_gen_if #(.CNT_W(CNT_W), .WIDTH_W(WIDTH_W), .GAP_W(GAP_W)) bus ();

  blip_burst_gen #(.CNT_W(CNT_W), .WIDTH_W(WIDTH_W), .GAP_W(GAP_W)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Burst as a function of k = cycles since acceptance (k=1 is the first output cycle)
  function automatic int clamp1(input int v);
    return (v == 0) ? 1 : v;
  endfunction
  function automatic int f_len(input int n, input int w, input int g);
    return n * w + (n - 1) * g;
  endfunction
  function automatic bit f_blip(input int k, input int w, input int g);
    return ((k - 1) % (w + g)) < w;
  endfunction
  function automatic logic [7:0] f_sent(input int k, input int w, input int g);
    return 8'(((k - 1) / (w + g)) + 1);
  endfunction
  function automatic bit f_free(input int n);
`ifdef BLIP_CONTINUOUS_EN
    return n == 0;
`else
    return (n < 0);
`endif
  endfunction

  int         m_n = 0, m_w = 1, m_g = 1, m_k = 0;
  bit         m_act = 1'b0, m_free = 1'b0;
  logic       exp_blip = 1'b0, exp_busy = 1'b0, exp_done = 1'b0, exp_ab = 1'b0;
  logic [7:0] exp_sent = 8'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act <= 1'b0; m_k <= 0;
      exp_blip <= 1'b0; exp_busy <= 1'b0; exp_done <= 1'b0; exp_ab <= 1'b0; exp_sent <= 8'd0;
    end else begin
      exp_done <= 1'b0;
      exp_ab   <= 1'b0;
      if (m_act) begin
        if (bus.abort) begin
          m_act <= 1'b0; exp_done <= 1'b1; exp_ab <= 1'b1; exp_busy <= 1'b0; exp_blip <= 1'b0;
        end else begin
          m_k <= m_k + 1;
          if (!m_free && (m_k + 1) > f_len(m_n, m_w, m_g)) begin
            m_act <= 1'b0; exp_done <= 1'b1; exp_busy <= 1'b0; exp_blip <= 1'b0;
            exp_sent <= 8'(m_n);
          end else begin
            exp_blip <= f_blip(m_k + 1, m_w, m_g);
            exp_sent <= f_sent(m_k + 1, m_w, m_g);
            exp_busy <= 1'b1;
          end
        end
      end else if (bus.start && !bus.abort) begin
        m_n <= int'(bus.burst_len);
        m_w <= clamp1(int'(bus.pulse_width));
        m_g <= clamp1(int'(bus.gap_len));
        m_k <= 1;
        m_free <= f_free(int'(bus.burst_len));
        if (bus.burst_len == 0 && !f_free(0)) begin
          exp_done <= 1'b1; exp_sent <= 8'd0; exp_busy <= 1'b0; exp_blip <= 1'b0;
        end else begin
          m_act <= 1'b1; exp_blip <= 1'b1; exp_busy <= 1'b1; exp_sent <= 8'd1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("model_blip", bus.blip_out, exp_blip);
      chk("model_busy", bus.busy, exp_busy);
      chk("model_done", bus.done, exp_done);
      chk("model_aborted", bus.aborted, exp_ab);
      chk("model_sent", bus.sent_count, exp_sent);
    end
  end

  // Event sink: counts rising edges of blip_out like the downstream counter would
  int   sink = 0;
  logic blip_prev = 1'b0;
  bit   sink_clr = 1'b0;
  always @(negedge clk) begin
    blip_prev <= bus.blip_out;
    if (sink_clr) sink <= 0;
    else if (bus.blip_out && !blip_prev) sink <= sink + 1;
  end

  // Call at a negedge; returns at the negedge of cycle T+1
  task automatic launch(input int n, input int w, input int g);
    bus.start = 1'b1;
    bus.burst_len = 8'(n);
    bus.pulse_width = 4'(w);
    bus.gap_len = 8'(g);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  logic [15:0] vb, vy, vd;
  int          dcnt;

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.burst_len = '0; bus.pulse_width = '0; bus.gap_len = '0;
    #12;
    chk("reset_blip", bus.blip_out, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_sent", bus.sent_count, 0);
    @(negedge clk); rst = 1'b0; chk_en = 1'b1;
    repeat (2) @(negedge clk);

    // nominal N=3 W=2 G=3
    launch(3, 2, 3);
    vb = '0; vy = '0; vd = '0;
    for (int i = 1; i <= 13; i++) begin
      if (i > 1) @(negedge clk);
      vb[i-1] = bus.blip_out; vy[i-1] = bus.busy; vd[i-1] = bus.done;
    end
    chk("nom_blip_pattern", vb[12:0], 13'h0C63);
    chk("nom_busy_pattern", vy[12:0], 13'h0FFF);
    chk("nom_done_pattern", vd[12:0], 13'h1000);
    chk("nom_aborted", bus.aborted, 0);
    chk("nom_sent", bus.sent_count, 3);
    repeat (2) @(negedge clk);

    // clamping N=2 W=0 G=0
    launch(2, 0, 0);
    vb = '0; vd = '0;
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) @(negedge clk);
      vb[i-1] = bus.blip_out; vd[i-1] = bus.done;
    end
    chk("clamp_blip_pattern", vb[3:0], 4'b0101);
    chk("clamp_done_pattern", vd[3:0], 4'b1000);
    chk("clamp_sent", bus.sent_count, 2);
    repeat (2) @(negedge clk);

    // abort in GAP after first pulse
    launch(10, 4, 4);
    repeat (6) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_blip", bus.blip_out, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 1);
    chk("abort_aborted", bus.aborted, 1);
    chk("abort_sent", bus.sent_count, 1);
    @(negedge clk);
    chk("abort_done_strobe", bus.done, 0);
    launch(1, 1, 1);
    chk("post_abort_blip", bus.blip_out, 1);
    @(negedge clk);
    chk("post_abort_done", bus.done, 1);
    chk("post_abort_aborted", bus.aborted, 0);
    chk("post_abort_sent", bus.sent_count, 1);
    @(negedge clk);

    // ignored start mid-burst and changed fields
    launch(2, 3, 1);
    bus.burst_len = 8'd7; bus.pulse_width = 4'd1; bus.gap_len = 8'd9;
    vb = '0; vd = '0;
    for (int i = 1; i <= 9; i++) begin
      if (i > 1) @(negedge clk);
      bus.start = (i == 3);
      vb[i-1] = bus.blip_out; vd[i-1] = bus.done;
    end
    bus.start = 1'b0;
    chk("ign_blip_pattern", vb[8:0], 9'h077);
    chk("ign_done_pattern", vd[8:0], 9'h080);
    bus.start = 1'b1; bus.abort = 1'b1; bus.burst_len = 8'd3;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 4; i++) begin
      dcnt += (bus.done || bus.busy) ? 1 : 0;
      @(negedge clk);
    end
    chk("ign_start_abort_idle", dcnt, 0);

    // async reset mid-burst
    launch(5, 4, 2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_blip", bus.blip_out, 0);
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_sent", bus.sent_count, 0);
    @(negedge clk); rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      dcnt += (bus.done || bus.blip_out) ? 1 : 0;
    end
    chk("rst_mid_no_done", dcnt, 0);

`ifdef BLIP_CONTINUOUS_EN
    // free-running, wraps sent_count
    sink_clr = 1'b1; @(negedge clk); sink_clr = 1'b0;
    launch(0, 1, 1);
    repeat (599) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("free_done", bus.done, 1);
    chk("free_aborted", bus.aborted, 1);
    chk("free_sent", bus.sent_count, 44);
    @(negedge clk);
    chk("free_sink_wrapped", (sink > 255) ? 1 : 0, 1);
    chk("free_sink_match", bus.sent_count, sink % 256);
`else
    // empty burst
    launch(0, 3, 3);
    chk("n0_done", bus.done, 1);
    chk("n0_busy", bus.busy, 0);
    chk("n0_blip", bus.blip_out, 0);
    chk("n0_sent", bus.sent_count, 0);
    chk("n0_aborted", bus.aborted, 0);
    @(negedge clk);
`endif

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      bus.start       = ($urandom_range(0, 3) == 0);
      bus.abort       = ($urandom_range(0, 19) == 0);
      bus.burst_len   = 8'($urandom_range(0, 6));
      bus.pulse_width = 4'($urandom_range(0, 3));
      bus.gap_len     = 8'($urandom_range(0, 3));
    end
    bus.start = 1'b0; bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
